// File: rtl/isp_stat_engine.sv
// isp_stat_engine: streaming image statistics engine.
// Takes one IMG_DIM x IMG_DIM RGB frame in raster order over a valid/ready
// handshake. It then returns one of two results:
//   - an auto-exposure brightness byte: the mean gray level after a per-channel
//     exposure ratio is applied;
//   - an auto-focus window index: the concentric centre window with the
//     largest mean neighbour contrast.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request pulse (honoured only while idle)
//   cfg_mode, cfg_ratio  0 = focus / 1 = exposure; exposure ratio code
//   pix_valid/pix_ready  pixel beat handshake
//   pix_r/g/b            pixel channels
//   busy                 engine is not idle
//   out_valid, out_data  one-cycle result strobe; data is 0 when not valid
module isp_stat_engine #(
  parameter int DW      = 8,
  parameter int IMG_DIM = 32,
  parameter int NUM_WIN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cfg_mode,
  input  logic [2:0]    cfg_ratio,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [DW-1:0] pix_r,
  input  logic [DW-1:0] pix_g,
  input  logic [DW-1:0] pix_b,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int LG  = $clog2(IMG_DIM);
  localparam int PCW = 2 * LG;
  localparam int G   = 2 * NUM_WIN;
  localparam int GC  = G * G;
  localparam int GIW = $clog2(GC);
  localparam int CW  = $clog2(G);
  localparam int AW  = DW + PCW;
  localparam int SW  = DW + $clog2(2 * GC);
  localparam int PW  = SW + $clog2(GC + 1);
  localparam int WIW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int LO  = IMG_DIM / 2 - NUM_WIN;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_CALC, S_CMP, S_OUT} state_t;

  // Per-channel exposure scaling; left shifts saturate instead of wrapping.
  function automatic logic [DW-1:0] scale_ch(input logic [DW-1:0] ch, input logic [2:0] code);
    case (code)
      3'd0:    scale_ch = {2'b00, ch[DW-1:2]};
      3'd1:    scale_ch = {1'b0, ch[DW-1:1]};
      3'd3:    scale_ch = ch[DW-1] ? {DW{1'b1}} : {ch[DW-2:0], 1'b0};
      3'd4:    scale_ch = (|ch[DW-1:DW-2]) ? {DW{1'b1}} : {ch[DW-3:0], 2'b00};
      default: scale_ch = ch;
    endcase
  endfunction

  // Luma approximation: r/4 + g/2 + b/4. Each term is truncated on its own,
  // so the sum always fits in DW bits.
  function automatic logic [DW-1:0] gray(input logic [DW-1:0] r, input logic [DW-1:0] g,
                                         input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {3'b000, r[DW-1:2]} + {2'b00, g[DW-1:1]} + {3'b000, b[DW-1:2]};
    gray = s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

  // Window k spans grid indices NUM_WIN-1-k .. NUM_WIN+k.
  function automatic logic in_win(input int idx, input int k);
    in_win = (idx >= NUM_WIN - 1 - k) && (idx <= NUM_WIN + k);
  endfunction

  // Pixel count of window k; this is the divisor of its average.
  function automatic logic [PW-1:0] win_area(input int k);
    win_area = PW'((2 * k + 2) * (2 * k + 2));
  endfunction

  state_t          state_q, state_d;
  logic            mode_q;
  logic [2:0]      ratio_q;
  logic [PCW-1:0]  pix_cnt_q;
  logic [AW-1:0]   acc_q;
  logic [DW-1:0]   grid_q [GC];
  logic [SW-1:0]   sum_q  [NUM_WIN];
  logic [SW-1:0]   sum_d  [NUM_WIN];
  logic [CW-1:0]   row_q, col_q;
  logic [WIW-1:0]  best_q, best_s;

  logic            beat_s, last_beat_s, in_grid_s;
  logic [LG-1:0]   pix_row_s, pix_col_s;
  logic [GIW-1:0]  cap_idx_s, cell_s, right_s, down_s;
  logic [DW-1:0]   gray_raw_s, gray_exp_s, h_diff_s, v_diff_s;

  assign pix_ready = (state_q == S_RECV);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_valid ? (mode_q ? acc_q[AW-1:PCW] : DW'(best_q)) : '0;

  assign beat_s      = pix_valid && (state_q == S_RECV);
  assign last_beat_s = beat_s && (pix_cnt_q == PCW'(IMG_DIM * IMG_DIM - 1));

  // Capture addressing: the centre G x G pixels map into the focus grid.
  // The bounds check is one bit wider so that IMG_DIM == G cannot wrap.
  assign pix_row_s  = pix_cnt_q[PCW-1:LG];
  assign pix_col_s  = pix_cnt_q[LG-1:0];
  assign in_grid_s  = ({1'b0, pix_row_s} >= (LG+1)'(LO)) && ({1'b0, pix_row_s} < (LG+1)'(LO + G)) &&
                      ({1'b0, pix_col_s} >= (LG+1)'(LO)) && ({1'b0, pix_col_s} < (LG+1)'(LO + G));
  assign cap_idx_s  = GIW'(pix_row_s - LG'(LO)) * GIW'(G) + GIW'(pix_col_s - LG'(LO));
  assign gray_raw_s = gray(pix_r, pix_g, pix_b);
  assign gray_exp_s = gray(scale_ch(pix_r, ratio_q), scale_ch(pix_g, ratio_q), scale_ch(pix_b, ratio_q));

  // Neighbour addresses for the cell in the CALC scan. At an edge the
  // address folds onto the cell itself; window membership already excludes
  // those pairs.
  assign cell_s   = GIW'(row_q) * GIW'(G) + GIW'(col_q);
  assign right_s  = (col_q == CW'(G - 1)) ? cell_s : cell_s + GIW'(1);
  assign down_s   = (row_q == CW'(G - 1)) ? cell_s : cell_s + GIW'(G);
  assign h_diff_s = abs_diff(grid_q[cell_s], grid_q[right_s]);
  assign v_diff_s = abs_diff(grid_q[cell_s], grid_q[down_s]);

  // Window sums: add each contrast to every window that contains both cells.
  always_comb begin
    for (int k = 0; k < NUM_WIN; k++) begin
      sum_d[k] = sum_q[k]
        + ((in_win(int'(row_q), k) && in_win(int'(col_q), k) && in_win(int'(col_q) + 1, k))
           ? SW'(h_diff_s) : SW'(0))
        + ((in_win(int'(col_q), k) && in_win(int'(row_q), k) && in_win(int'(row_q) + 1, k))
           ? SW'(v_diff_s) : SW'(0));
    end
  end

  // Exact argmax of S_k / area_k using cross-multiplication. A strict
  // greater-than keeps the smaller index when two averages tie.
  always_comb begin
    best_s = '0;
    for (int k = 1; k < NUM_WIN; k++) begin
      best_s = ((PW'(sum_q[k]) * win_area(int'(best_s))) > (PW'(sum_q[best_s]) * win_area(k)))
               ? WIW'(k) : best_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RECV; else state_d = S_IDLE;
      S_RECV: if (last_beat_s) state_d = mode_q ? S_OUT : S_CALC; else state_d = S_RECV;
      S_CALC: if ((row_q == CW'(G - 1)) && (col_q == CW'(G - 1))) state_d = S_CMP;
              else state_d = S_CALC;
      S_CMP:  state_d = S_OUT;
      S_OUT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request configuration, accumulators and scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      ratio_q   <= 3'd0;
      pix_cnt_q <= '0;
      acc_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      best_q    <= '0;
      for (int k = 0; k < NUM_WIN; k++) sum_q[k] <= '0;
      for (int i = 0; i < GC; i++) grid_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          mode_q    <= cfg_mode;
          ratio_q   <= cfg_ratio;
          pix_cnt_q <= '0;
          acc_q     <= '0;
          row_q     <= '0;
          col_q     <= '0;
          for (int k = 0; k < NUM_WIN; k++) sum_q[k] <= '0;
        end
        S_RECV: if (beat_s) begin
          pix_cnt_q <= pix_cnt_q + PCW'(1);
          if (mode_q) acc_q <= acc_q + AW'(gray_exp_s);
          if (in_grid_s) grid_q[cap_idx_s] <= gray_raw_s;
        end
        S_CALC: begin
          sum_q <= sum_d;
          if (col_q == CW'(G - 1)) begin
            col_q <= '0;
            row_q <= row_q + CW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        S_CMP:   best_q <= best_s;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isp_stat_engine.sv
module tb_isp_stat_engine;
  localparam int DW   = 8;
  localparam int IMG  = 32;
  localparam int NPIX = IMG * IMG;

  logic          clk = 1'b0;
  logic          rst, start, cfg_mode;
  logic [2:0]    cfg_ratio;
  logic          pix_valid, pix_ready;
  logic [DW-1:0] pix_r, pix_g, pix_b;
  logic          busy, out_valid;
  logic [DW-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  // pat: 0 uniform, 1 checkerboard 0/val, 2 single pixel at (pos,pos)
  typedef struct {
    logic       mode;
    logic [2:0] ratio;
    int         pat;
    int         val;
    int         pos;
    bit         stall;
    int         exp;
    int         lat;
  } vec_t;

  typedef struct {
    int exp;
    int lat;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[12];

  isp_stat_engine #(.DW(DW), .IMG_DIM(IMG), .NUM_WIN(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_ratio(cfg_ratio),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .busy(busy), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix_at(input vec_t v, input int idx);
    int row, col;
    row = idx / IMG;
    col = idx % IMG;
    case (v.pat)
      0:       return DW'(v.val);
      1:       return ((row + col) % 2 == 1) ? DW'(v.val) : DW'(0);
      2:       return (row == v.pos && col == v.pos) ? DW'(v.val) : DW'(0);
      default: return DW'(0);
    endcase
  endfunction

  // Feed beats until n_beats are accepted, with optional random gaps and
  // start pulses that the engine should ignore mid-frame.
  task automatic send_beats(input vec_t v, input int n_beats);
    int idx = 0;
    int guard = 0;
    bit take;
    while (idx < n_beats && guard < 8 * NPIX) begin
      pix_valid = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      start     = v.stall && ($urandom_range(0, 15) == 0);
      pix_r = pix_at(v, idx);
      pix_g = pix_at(v, idx);
      pix_b = pix_at(v, idx);
      take = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (take) idx++;
      guard++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (idx < n_beats) check("beat_timeout", idx, n_beats);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    sb_t e;
    int  lat = 0;
    bit  seen = 0;
    e.exp = v.exp;
    e.lat = v.lat;
    sb_q.push_back(e);
    // a beat offered while idle must not be taken
    pix_valid = 1'b1;
    pix_r = 8'hFF; pix_g = 8'hFF; pix_b = 8'hFF;
    check($sformatf("%s_ready_idle", tag), pix_ready, 0);
    check($sformatf("%s_busy_idle", tag), busy, 0);
    start = 1'b1; cfg_mode = v.mode; cfg_ratio = v.ratio;
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b0;
    check($sformatf("%s_busy_recv", tag), busy, 1);
    check($sformatf("%s_ready_recv", tag), pix_ready, 1);
    send_beats(v, NPIX);
    for (int i = 1; i <= 100 && !seen; i++) begin
      if (out_valid) begin
        seen = 1;
        lat  = i;
      end else begin
        check($sformatf("%s_ready_wait", tag), pix_ready, 0);
        start = (i == 1);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    if (sb_q.size() > 0) e = sb_q.pop_front();
    if (!seen) begin
      check($sformatf("%s_out_valid_timeout", tag), out_valid, 1);
    end else begin
      check($sformatf("%s_data", tag), out_data, e.exp);
      check($sformatf("%s_latency", tag), lat, e.lat);
      @(posedge clk); #1;
      check($sformatf("%s_valid_oneshot", tag), out_valid, 0);
      check($sformatf("%s_data_zero", tag), out_data, 0);
      check($sformatf("%s_busy_after", tag), busy, 0);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_ratio = 3'd0;
    pix_valid = 1'b0; pix_r = '0; pix_g = '0; pix_b = '0;

    //             mode  ratio pat val pos stall exp lat
    vecs[0]  = '{1'b1, 3'd2, 0, 200, 0,  1'b0, 200, 1};
    vecs[1]  = '{1'b1, 3'd0, 0, 200, 0,  1'b0, 49,  1};
    vecs[2]  = '{1'b1, 3'd3, 0, 200, 0,  1'b0, 253, 1};
    vecs[3]  = '{1'b1, 3'd4, 0, 200, 0,  1'b0, 253, 1};
    vecs[4]  = '{1'b1, 3'd6, 0, 200, 0,  1'b0, 200, 1};
    vecs[5]  = '{1'b0, 3'd0, 1, 200, 0,  1'b0, 2,   38};
    vecs[6]  = '{1'b0, 3'd4, 2, 200, 14, 1'b0, 1,   38};
    vecs[7]  = '{1'b0, 3'd0, 2, 200, 13, 1'b0, 2,   38};
    vecs[8]  = '{1'b0, 3'd0, 0, 200, 0,  1'b0, 0,   38};
    vecs[9]  = '{1'b1, 3'd2, 0, 200, 0,  1'b1, 200, 1};
    vecs[10] = '{1'b1, 3'd1, 1, 200, 0,  1'b1, 50,  1};
    vecs[11] = '{1'b0, 3'd0, 1, 200, 0,  1'b1, 2,   38};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", pix_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort an exposure frame at beat 500 with bright pixels
    v = '{1'b1, 3'd2, 0, 255, 0, 1'b0, 0, 1};
    start = 1'b1; cfg_mode = 1'b1; cfg_ratio = 3'd2;
    @(posedge clk); #1;
    start = 1'b0;
    send_beats(v, 500);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_recv_busy", busy, 0);
    check("abort_recv_ready", pix_ready, 0);
    check("abort_recv_valid", out_valid, 0);
    check("abort_recv_data", out_data, 0);
    rst = 1'b0;
    run_vec('{1'b1, 3'd2, 0, 100, 0, 1'b0, 100, 1}, "fresh_exp");

    // abort a focus request in the middle of CALC
    v = '{1'b0, 3'd0, 1, 200, 0, 1'b0, 0, 38};
    start = 1'b1; cfg_mode = 1'b0; cfg_ratio = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    send_beats(v, NPIX);
    repeat (10) @(posedge clk);
    #1;
    check("abort_calc_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_calc_busy", busy, 0);
    check("abort_calc_valid", out_valid, 0);
    rst = 1'b0;
    run_vec('{1'b0, 3'd0, 2, 200, 14, 1'b0, 1, 38}, "fresh_focus");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/isp_stat_engine.md
Name: isp_stat_engine

Overview:
- Streaming statistics engine for the image-signal path: consumes one RGB frame of IMG_DIM x IMG_DIM pixels in raster order.
- Per request, returns either an auto-exposure brightness byte or an auto-focus window index.
- Parametrised successor of the fixed 32x32 / 3-window / 4-ratio focus-exposure datapath: pixel width, frame size, window count and ratio set are generalised.
- Adds a valid/ready pixel handshake, a 4x exposure ratio with saturation, and exact rational comparison of focus averages.

Parameters:
- DW, 8: bits per colour channel and per output byte.
- IMG_DIM, 32: frame width = height; power of two, >= 2*NUM_WIN.
- NUM_WIN, 3: number of concentric focus windows, sizes 2,4,...,2*NUM_WIN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- cfg_mode  in  1  0 = auto-focus, 1 = auto-exposure; latched on start.
- cfg_ratio  in  3  exposure ratio code; latched on start.
- pix_valid  in  1  pixel beat valid.
- pix_ready  out  1  engine accepts a beat.
- pix_r, pix_g, pix_b  in  DW each  channel values.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  DW  result; 0 whenever out_valid = 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: pix_ready = 0, busy = 0, out_valid = 0, out_data = 0, state = IDLE, all accumulators cleared.
- rst asserted in any state, including mid-frame or mid-calculation, returns the engine to IDLE on the next edge and discards partial results.
- States:
  - IDLE: start = 1 -> RECV. start in any other state is ignored.
  - RECV: pix_ready = 1. A beat is accepted when pix_valid & pix_ready. A pixel counter runs 0..IMG_DIM^2-1.
  - Last beat accepted: exposure -> OUT; focus -> CALC.
  - CALC: exactly (2*NUM_WIN)^2 cycles, then CMP.
  - CMP: 1 cycle, then OUT.
  - OUT: out_valid = 1 for exactly one cycle, then IDLE.
- pix_ready = 0 outside RECV. Beats offered then are not consumed.
- Latency measured from the cycle of the last accepted beat:
  - exposure: out_valid in the next cycle.
  - focus: out_valid (2*NUM_WIN)^2 + 2 cycles later (38 at defaults).
- Gray conversion: gray = (r>>2) + (g>>1) + (b>>2), each term truncated; the result fits in DW bits.
- Exposure ratio, applied per channel before gray conversion:
  - code 0: >>2
  - code 1: >>1
  - code 2: x1
  - code 3: <<1, saturating to 2^DW-1 when the MSB is set
  - code 4: <<2, saturating to 2^DW-1 when either of the top two bits is set
  - codes 5-7: treated as 2
- Exposure accumulator: DW + 2*log2(IMG_DIM) bits. out_data = sum >> (2*log2(IMG_DIM)), truncated.
- Focus capture: gray of pixels at rows/cols IMG_DIM/2-NUM_WIN .. IMG_DIM/2+NUM_WIN-1 is stored in a (2N)x(2N) register grid, N = NUM_WIN. Ratio is ignored in focus mode.
- Window k (0..N-1) covers grid indices N-1-k .. N+k.
- Contrast of a pair = |a-b|.
- CALC visits one grid cell (r,c) per cycle in raster order:
  - adds the horizontal contrast (c,c+1) when c < 2N-1;
  - adds the vertical contrast (r,r+1) when r < 2N-1;
  - each contrast goes into every window sum S_k containing both cells.
- CMP: the average of window k is S_k / (2k+2)^2. Averages are compared exactly by cross-multiplication: S_i*(2j+2)^2 vs S_j*(2i+2)^2.
- out_data = index of the largest average. Ties go to the smaller index; an all-zero frame therefore gives 0.
- Pixel stalls: gaps in pix_valid during RECV stall the counter only. There is no timeout.

Test Plan:
- Exposure, ratio 2, all channels 200, no stalls: gray 200 per pixel -> out_data = 200, out_valid exactly 1 cycle after the 1024th beat, busy low the following cycle.
- Exposure, ratios 0/3/4, all channels 200 -> out_data 49 / 253 / 253 (saturated channel 255 -> 63+127+63). Ratio code 6 -> 200.
- Focus, r=g=b with checkerboard 0/200 over the whole frame -> window averages 200/300/333 -> out_data = 2, out_valid 38 cycles after the last beat.
- Focus, all 0 except pixel (14,14) = 200 -> averages 0/25/22.2 -> out_data = 1. Same frame with only (13,13) = 200 -> out_data = 2. Uniform frame -> out_data = 0 (tie rule).
- Handshake: random pix_valid gaps; start pulsed during RECV and CALC -> ignored; pix_ready low outside RECV. Exposure results are identical to the no-stall case.
- Reset: rst mid-frame at beat 500 -> next cycle IDLE, all outputs 0. A fresh request then completes correctly with no residue from the aborted frame.
